// File: rtl/link_bringup_pkg.sv
// Shared types for the link/DDR bring-up sequencer: FSM state encoding and fault codes.
package link_bringup_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    WAIT_GT  = 3'd1,
    WAIT_BLK = 3'd2,
    WAIT_DDR = 3'd3,
    SETTLE   = 3'd4,
    READY    = 3'd5,
    FAULT    = 3'd6
  } state_t;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_GT   = 2'd1;
  localparam logic [1:0] FC_BLK  = 2'd2;
  localparam logic [1:0] FC_DDR  = 2'd3;

endpackage

// File: rtl/link_bringup_ctrl_sync_2ff.sv
// Two-flop synchroniser for one asynchronous status bit, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= 1'b0;
      q_reg    <= 1'b0;
    end else begin
      meta_reg <= d;
      q_reg    <= meta_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/link_bringup_ctrl.sv
// Bring-up sequencer for the QSFP 25GE MAC/GT and DDR4: reset, lock waits, settle, READY/FAULT.
// Optional macro LINK_BRINGUP_STATS_EN adds the saturating link_drop_cnt output.
module link_bringup_ctrl
  import link_bringup_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1048576,
  parameter int unsigned SETTLE_CYCLES = 256,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned CNT_W         = 24
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       gt_locked_in,
  input  logic       block_lock_in,
  input  logic       ddr_calib_done_in,
  input  logic       restart,
  output logic       gt_reset_out,
  output logic       mac_ready,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
`ifdef LINK_BRINGUP_STATS_EN
  ,
  output logic [15:0] link_drop_cnt
`endif
);

  logic [2:0] status_in;
  logic [2:0] status_s;
  logic       gt_s, blk_s, ddr_s;

  assign status_in = {ddr_calib_done_in, block_lock_in, gt_locked_in};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_2ff u_sync (
        .clk (clk),
        .rst (sys_reset),
        .d   (status_in[gi]),
        .q   (status_s[gi])
      );
    end
  endgenerate

  assign gt_s  = status_s[0];
  assign blk_s = status_s[1];
  assign ddr_s = status_s[2];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] timer_reg, timer_next;
  logic [1:0]       retry_reg, retry_next;
  logic [1:0]       code_reg, code_next;
  logic             gt_reset_reg, gt_reset_next;
  logic             mac_ready_reg, mac_ready_next;
  logic             fault_reg, fault_next;
  logic             do_retry;
  logic [1:0]       retry_code;
  logic             lock_timeout;

  assign lock_timeout = (timer_reg == CNT_W'(LOCK_TIMEOUT - 1));

  // State register; the outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_reg     <= RST_HOLD;
      timer_reg     <= '0;
      retry_reg     <= 2'd0;
      code_reg      <= FC_NONE;
      gt_reset_reg  <= 1'b1;
      mac_ready_reg <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      retry_reg     <= retry_next;
      code_reg      <= code_next;
      gt_reset_reg  <= gt_reset_next;
      mac_ready_reg <= mac_ready_next;
      fault_reg     <= fault_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    code_next  = code_reg;
    do_retry   = 1'b0;
    retry_code = FC_NONE;
    if (restart) begin
      state_next = RST_HOLD;
      retry_next = 2'd0;
      code_next  = FC_NONE;
    end else begin
      // Within each state, lock loss is checked before progress, and progress before timeout.
      case (state_reg)
        RST_HOLD: begin
          if (timer_reg == CNT_W'(RESET_CYCLES - 1)) state_next = WAIT_GT;
        end
        WAIT_GT: begin
          if (gt_s)              state_next = WAIT_BLK;
          else if (lock_timeout) begin do_retry = 1'b1; retry_code = FC_GT; end
        end
        WAIT_BLK: begin
          if (!gt_s)             begin do_retry = 1'b1; retry_code = FC_GT; end
          else if (blk_s)        state_next = WAIT_DDR;
          else if (lock_timeout) begin do_retry = 1'b1; retry_code = FC_BLK; end
        end
        WAIT_DDR: begin
          if (!gt_s)             begin do_retry = 1'b1; retry_code = FC_GT; end
          else if (!blk_s)       begin do_retry = 1'b1; retry_code = FC_BLK; end
          else if (ddr_s)        state_next = SETTLE;
          else if (lock_timeout) begin state_next = FAULT; code_next = FC_DDR; end
        end
        SETTLE: begin
          if (!gt_s)             begin do_retry = 1'b1; retry_code = FC_GT; end
          else if (!blk_s)       begin do_retry = 1'b1; retry_code = FC_BLK; end
          else if (!ddr_s)       begin state_next = FAULT; code_next = FC_DDR; end
          else if (timer_reg == CNT_W'(SETTLE_CYCLES - 1)) state_next = READY;
        end
        READY: begin
          if (!gt_s)             begin do_retry = 1'b1; retry_code = FC_GT; end
          else if (!blk_s)       begin do_retry = 1'b1; retry_code = FC_BLK; end
          else if (!ddr_s)       begin state_next = FAULT; code_next = FC_DDR; end
        end
        FAULT:   state_next = FAULT;
        default: state_next = FAULT;
      endcase

      if (do_retry) begin
        if (retry_reg == 2'(MAX_RETRY)) begin
          state_next = FAULT;
          code_next  = retry_code;
        end else begin
          retry_next = retry_reg + 2'd1;
          state_next = RST_HOLD;
        end
      end

      if (state_next == READY && state_reg != READY) retry_next = 2'd0;
    end
  end

  always_comb begin
    timer_next     = (restart || state_next != state_reg) ? '0 : timer_reg + 1'b1;
    gt_reset_next  = (state_next == RST_HOLD) || (state_next == FAULT);
    mac_ready_next = (state_next == READY);
    fault_next     = (state_next == FAULT);
  end

  assign gt_reset_out = gt_reset_reg;
  assign mac_ready    = mac_ready_reg;
  assign fault        = fault_reg;
  assign fault_code   = code_reg;
  assign state        = state_reg;
  assign retry_cnt    = retry_reg;

`ifdef LINK_BRINGUP_STATS_EN
  logic [15:0] drop_cnt_reg;
  logic        drop_evt;

  // Only lock loss out of READY counts; restart and DDR loss are not link drops.
  assign drop_evt = !restart && (state_reg == READY) && (!gt_s || !blk_s);

  always_ff @(posedge clk or posedge sys_reset) begin
    if (sys_reset)                               drop_cnt_reg <= 16'd0;
    else if (drop_evt && drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end

  assign link_drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_link_bringup_ctrl.sv
// Self-checking bench for link_bringup_ctrl; expected timelines are derived arithmetically
// from the bring-up rules (3-cycle input latency, fixed hold/timeout/settle lengths).
module tb_link_bringup_ctrl;

  localparam int RC = 4;
  localparam int LT = 100;
  localparam int SC = 8;
  localparam int MR = 2;
  localparam int ATTEMPT = RC + LT;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b0;
  logic       gt_locked_in = 1'b0;
  logic       block_lock_in = 1'b0;
  logic       ddr_calib_done_in = 1'b0;
  logic       restart = 1'b0;
  logic       gt_reset_out, mac_ready, fault;
  logic [1:0] fault_code, retry_cnt;
  logic [2:0] state;
`ifdef LINK_BRINGUP_STATS_EN
  logic [15:0] link_drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [9:0] obs;
  assign obs = {state, gt_reset_out, mac_ready, fault, fault_code, retry_cnt};

  always #5 clk = ~clk;

  link_bringup_ctrl #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .SETTLE_CYCLES(SC),
    .MAX_RETRY    (MR),
    .CNT_W        (24)
  ) dut (
    .clk              (clk),
    .sys_reset        (sys_reset),
    .gt_locked_in     (gt_locked_in),
    .block_lock_in    (block_lock_in),
    .ddr_calib_done_in(ddr_calib_done_in),
    .restart          (restart),
    .gt_reset_out     (gt_reset_out),
    .mac_ready        (mac_ready),
    .fault            (fault),
    .fault_code       (fault_code),
    .state            (state),
    .retry_cnt        (retry_cnt)
`ifdef LINK_BRINGUP_STATS_EN
    ,
    .link_drop_cnt    (link_drop_cnt)
`endif
  );

  // Outputs implied by a state: reset in RST_HOLD/FAULT, ready only in READY, fault only in FAULT.
  function automatic logic [9:0] expv(int st, int fc, int rc);
    logic gr, mr, f;
    gr = (st == 0) || (st == 6);
    mr = (st == 5);
    f  = (st == 6);
    return {3'(st), gr, mr, f, 2'(fc), 2'(rc)};
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    sys_reset = 1'b1;
    restart = 1'b0;
    gt_locked_in = 1'b0;
    block_lock_in = 1'b0;
    ddr_calib_done_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sys_reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    #2;
    sys_reset = 1'b1;
    #1;
    e = expv(0, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset_async got=%b exp=%b", obs, e);
    end
`ifdef LINK_BRINGUP_STATS_EN
    n_cmp++;
    if (link_drop_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_drop_cnt got=%0d exp=0", link_drop_cnt);
    end
`endif
    do_reset();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL reset_release got=%b exp=%b", obs, e);
    end
    $display("test_reset done");
  endtask

  task automatic test_nominal(input int tg, input int tb, input int td);
    int t1, t2, t3, t4, st;
    logic [9:0] e;
    do_reset();
    t1 = imax(RC, tg + 2) + 1;
    t2 = imax(t1, tb + 2) + 1;
    t3 = imax(t2, td + 2) + 1;
    t4 = t3 + SC;
    while (cyc <= t4 + 6) begin
      gt_locked_in      = (cyc >= tg);
      block_lock_in     = (cyc >= tb);
      ddr_calib_done_in = (cyc >= td);
      if      (cyc < RC) st = 0;
      else if (cyc < t1) st = 1;
      else if (cyc < t2) st = 2;
      else if (cyc < t3) st = 3;
      else if (cyc < t4) st = 4;
      else               st = 5;
      e = expv(st, 0, 0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      tick();
    end
    $display("test_nominal gt=%0d blk=%0d ddr=%0d ready_at=%0d", tg, tb, td, t4);
  endtask

  task automatic test_gt_never_locks();
    int st, rc, fc;
    logic [9:0] e;
    do_reset();
    while (cyc <= ATTEMPT * (MR + 1) + 80) begin
      if (cyc >= ATTEMPT * (MR + 1)) begin
        st = 6; rc = MR; fc = 1;
      end else begin
        st = ((cyc % ATTEMPT) < RC) ? 0 : 1;
        rc = cyc / ATTEMPT;
        fc = 0;
      end
      e = expv(st, fc, rc);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL gt_never_locks cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      tick();
    end
    $display("test_gt_never_locks done");
  endtask

  task automatic test_link_drop(input int k);
    int st, rc;
    logic [9:0] e;
    do_reset();
    while (cyc <= k + 24) begin
      gt_locked_in      = 1'b1;
      ddr_calib_done_in = 1'b1;
      block_lock_in     = (cyc != k);
      rc = 0;
      if      (cyc < RC)      st = 0;
      else if (cyc < RC + 1)  st = 1;
      else if (cyc < RC + 2)  st = 2;
      else if (cyc < RC + 3)  st = 3;
      else if (cyc < RC + 3 + SC) st = 4;
      else if (cyc < k + 3)   st = 5;
      else begin
        rc = 1;
        if      (cyc < k + 3 + RC)      st = 0;
        else if (cyc < k + 4 + RC)      st = 1;
        else if (cyc < k + 5 + RC)      st = 2;
        else if (cyc < k + 6 + RC)      st = 3;
        else if (cyc < k + 6 + RC + SC) st = 4;
        else begin st = 5; rc = 0; end
      end
      e = expv(st, 0, rc);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL link_drop cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      tick();
    end
`ifdef LINK_BRINGUP_STATS_EN
    n_cmp++;
    if (link_drop_cnt !== 16'd1) begin
      n_bad++;
      $display("FAIL link_drop_cnt got=%0d exp=1", link_drop_cnt);
    end
`endif
    $display("test_link_drop drop_at=%0d", k);
  endtask

  task automatic test_ddr_timeout_and_restart(input int tg);
    int st, rc, fc, tw, tf;
    logic [9:0] e;
    do_reset();
    // GT lock arrives during the second attempt; DDR never calibrates.
    tw = imax(ATTEMPT + RC, tg + 2) + 1;
    tf = tw + 1 + LT;
    while (cyc <= tf + 10) begin
      gt_locked_in  = (cyc >= tg);
      block_lock_in = 1'b1;
      fc = 0; rc = 0;
      if      (cyc < RC)           st = 0;
      else if (cyc < ATTEMPT)      st = 1;
      else begin
        rc = 1;
        if      (cyc < ATTEMPT + RC) st = 0;
        else if (cyc < tw)           st = 1;
        else if (cyc < tw + 1)       st = 2;
        else if (cyc < tf)           st = 3;
        else begin st = 6; fc = 3; end
      end
      e = expv(st, fc, rc);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL ddr_timeout cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      tick();
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    e = expv(0, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL restart_from_fault got=%b exp=%b", obs, e);
    end
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL restart_hold got=%b exp=%b", obs, e);
    end
    $display("test_ddr_timeout_and_restart gt_at=%0d fault_at=%0d", tg, tf);
  endtask

  task automatic test_restart_settle(input int r);
    int st;
    logic [9:0] e;
    do_reset();
    while (cyc <= r + 20) begin
      gt_locked_in      = 1'b1;
      block_lock_in     = 1'b1;
      ddr_calib_done_in = 1'b1;
      restart           = (cyc == r);
      if      (cyc < RC)     st = 0;
      else if (cyc < RC + 1) st = 1;
      else if (cyc < RC + 2) st = 2;
      else if (cyc < RC + 3) st = 3;
      else if (cyc <= r)     st = 4;
      else if (cyc < r + 1 + RC) st = 0;
      else if (cyc < r + 2 + RC) st = 1;
      else if (cyc < r + 3 + RC) st = 2;
      else if (cyc < r + 4 + RC) st = 3;
      else if (cyc < r + 4 + RC + SC) st = 4;
      else st = 5;
      e = expv(st, 0, 0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL restart_settle cyc=%0d got=%b exp=%b", cyc, obs, e);
      end
      tick();
    end
    restart = 1'b0;
    $display("test_restart_settle restart_at=%0d", r);
  endtask

  task automatic test_sys_reset_mid_blk();
    logic [9:0] e;
    do_reset();
    gt_locked_in = 1'b1;
    // Block lock never comes: first WAIT_BLK times out, second attempt is in WAIT_BLK at 115.
    while (cyc < 115) tick();
    e = expv(2, 0, 1);
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL pre_reset_blk got=%b exp=%b", obs, e);
    end
    #3;
    sys_reset = 1'b1;
    #1;
    e = expv(0, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL sys_reset_async got=%b exp=%b", obs, e);
    end
    do_reset();
    $display("test_sys_reset_mid_blk done");
  endtask

  initial begin
    test_reset();
    test_nominal(10, 20, 30);
    for (int i = 0; i < 3; i++) begin
      int tg, tb, td;
      tg = int'($urandom_range(0, 30));
      tb = tg + int'($urandom_range(1, 30));
      td = tb + int'($urandom_range(1, 30));
      test_nominal(tg, tb, td);
    end
    test_gt_never_locks();
    test_link_drop(RC + 3 + SC + int'($urandom_range(2, 20)));
    test_ddr_timeout_and_restart(ATTEMPT + int'($urandom_range(2, 30)));
    test_restart_settle(RC + 3 + int'($urandom_range(0, SC - 1)));
    test_sys_reset_mid_blk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
